// File: rtl/dct16_pkg.sv
// dct16_pkg: sizes, default widths and read-FSM states shared by the dct16 stages.
`default_nettype none

package dct16_pkg;
  localparam int N                 = 16;
  localparam int HALF              = 8;
  localparam int QUARTER           = 4;
  localparam int CNT_W             = 4;
  localparam int DEFAULT_IN_WIDTH  = 16;
  localparam int DEFAULT_OUT_WIDTH = 17;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OUT  = 1'b1
  } rd_state_t;
endpackage

`default_nettype wire

// File: rtl/dct16_pp_bank.sv
// dct16_pp_bank: two 16-entry ping-pong sample banks with write pointer and per-bank full flags.
`default_nettype none

module dct16_pp_bank
  import dct16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_IN_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_sample,
  input  logic                   rd_bank,
  input  logic                   drain_done,
  output logic                   wr_bank,
  output logic [1:0]             full,
  output logic                   set_full,
  output logic [2*N*WIDTH-1:0]   data
);

  logic [CNT_W-1:0] wr_cnt;
  logic [WIDTH-1:0] mem [2*N];
  logic [1:0]       set_vec;
  logic [1:0]       clr_vec;

  assign set_full = in_valid && (wr_cnt == CNT_W'(N - 1));
  assign set_vec  = set_full   ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_vec  = drain_done ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      if (in_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (set_full) wr_bank <= ~wr_bank;
      end
      // a set on one bank and a release of the other can share an edge; both must land
      full <= (full & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) mem[{wr_bank, wr_cnt}] <= in_sample;
  end

  for (genvar i = 0; i < 2 * N; i++) begin : g_flat
    assign data[i*WIDTH +: WIDTH] = mem[i];
  end

  a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid |-> !full[wr_bank]);

endmodule

`default_nettype wire

// File: rtl/dct16_stage2.sv
// dct16_stage2: 8-point even butterfly plus odd pass-through on ping-pong buffered 16-sample blocks.
// Optional frame flags out_first/out_last are enabled by DCT16_STAGE2_FRAME_FLAGS_EN.
`default_nettype none

module dct16_stage2
  import dct16_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = DEFAULT_IN_WIDTH,
  parameter int DATA_OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [DATA_IN_WIDTH-1:0]  in_sample,
  output logic                      out_valid,
  output logic [DATA_OUT_WIDTH-1:0] out_sample
`ifdef DCT16_STAGE2_FRAME_FLAGS_EN
  ,
  output logic                      out_first,
  output logic                      out_last
`endif
);

  rd_state_t                          state, state_nxt;
  logic                               rd_bank, rd_bank_nxt;
  logic [CNT_W-1:0]                   rd_cnt, rd_cnt_nxt;
  logic                               emit, drain_done, other_ready;
  logic                               wr_bank, set_full;
  logic [1:0]                         full;
  logic [2*N*DATA_IN_WIDTH-1:0]       data;
  logic [DATA_IN_WIDTH-1:0]           words [2*N];
  logic signed [DATA_IN_WIDTH-1:0]    ya, yb;
  logic signed [DATA_OUT_WIDTH-1:0]   ea, eb, z;

  dct16_pp_bank #(.WIDTH(DATA_IN_WIDTH)) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .rd_bank    (rd_bank),
    .drain_done (drain_done),
    .wr_bank    (wr_bank),
    .full       (full),
    .set_full   (set_full),
    .data       (data)
  );

  always_comb begin
    for (int i = 0; i < 2 * N; i++) words[i] = data[i*DATA_IN_WIDTH +: DATA_IN_WIDTH];
  end

  // the partner of y(k) in the even half is y(7-k), i.e. the low 3 index bits inverted
  assign ya = words[{rd_bank, rd_cnt}];
  assign yb = words[{rd_bank, 1'b0, ~rd_cnt[2:0]}];
  assign ea = DATA_OUT_WIDTH'(ya);
  assign eb = DATA_OUT_WIDTH'(yb);

  always_comb begin
    if (rd_cnt >= CNT_W'(HALF))         z = ea;
    else if (rd_cnt >= CNT_W'(QUARTER)) z = eb - ea;
    else                                z = ea + eb;
  end

  assign other_ready = full[~rd_bank] || (set_full && (wr_bank != rd_bank));

  always_comb begin
    state_nxt   = state;
    rd_cnt_nxt  = rd_cnt;
    rd_bank_nxt = rd_bank;
    emit        = 1'b0;
    drain_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (full[rd_bank]) begin
          emit       = 1'b1;
          rd_cnt_nxt = rd_cnt + 1'b1;
          state_nxt  = S_OUT;
        end
      end
      S_OUT: begin
        emit = 1'b1;
        if (rd_cnt == CNT_W'(N - 1)) begin
          drain_done  = 1'b1;
          rd_bank_nxt = ~rd_bank;
          rd_cnt_nxt  = '0;
          state_nxt   = other_ready ? S_OUT : S_IDLE;
        end else begin
          rd_cnt_nxt = rd_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_bank    <= 1'b0;
      rd_cnt     <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      state     <= state_nxt;
      rd_bank   <= rd_bank_nxt;
      rd_cnt    <= rd_cnt_nxt;
      out_valid <= emit;
      if (emit) out_sample <= z;
    end
  end

`ifdef DCT16_STAGE2_FRAME_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_first <= emit && (rd_cnt == '0);
      out_last  <= emit && (rd_cnt == CNT_W'(N - 1));
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dct16_stage2.sv
// tb_dct16_stage2: randomized self-checking bench for dct16_stage2 against a block-level reference model.
`default_nettype none

module tb_dct16_stage2;

  typedef int iq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_sample = '0;
  logic        out_valid;
  logic [16:0] out_sample;
`ifdef DCT16_STAGE2_FRAME_FLAGS_EN
  logic        out_first;
  logic        out_last;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [16:0] outq[$];
  int          outc[$];
  logic        firstq[$];
  logic        lastq[$];

  dct16_stage2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_sample (out_sample)
`ifdef DCT16_STAGE2_FRAME_FLAGS_EN
    ,
    .out_first  (out_first),
    .out_last   (out_last)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      outq.push_back(out_sample);
      outc.push_back(cyc);
`ifdef DCT16_STAGE2_FRAME_FLAGS_EN
      firstq.push_back(out_first);
      lastq.push_back(out_last);
`else
      firstq.push_back(1'b0);
      lastq.push_back(1'b0);
`endif
    end
  end

  // Reference: each 16-sample block y maps to z by the even butterfly / odd pass-through rules.
  function automatic iq_t model(input iq_t ys);
    iq_t z;
    int  y[16];
    for (int b = 0; b + 16 <= ys.size(); b += 16) begin
      for (int k = 0; k < 16; k++) y[k] = ys[b+k];
      for (int k = 0; k < 16; k++) begin
        if (k < 4)      z.push_back(y[k] + y[7-k]);
        else if (k < 8) z.push_back(y[7-k] - y[k]);
        else            z.push_back(y[k]);
      end
    end
    return z;
  endfunction

  function automatic iq_t ramp(input int n, input int base);
    iq_t q;
    for (int i = 0; i < n; i++) q.push_back(base + (i % 16) + 16 * (i / 16) * 0 + 0);
    return q;
  endfunction

  function automatic iq_t rand_block(input int n);
    iq_t q;
    for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(65535, 0)) - 32768);
    return q;
  endfunction

  task automatic clear_mon();
    outq.delete();
    outc.delete();
    firstq.delete();
    lastq.delete();
  endtask

  task automatic drive_stream(input iq_t ys, input int gap_pct, output int last_cyc);
    int v;
    last_cyc = cyc;
    foreach (ys[i]) begin
      while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      v = ys[i];
      in_valid  = 1'b1;
      in_sample = v[15:0];
      @(posedge clk); #1;
      last_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int b = 0;
    while (outq.size() < n && b < budget) begin
      @(posedge clk); #1;
      b++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sample !== 17'd0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b out_sample=%0d, required 0/0", out_valid, out_sample);
    end
    @(negedge clk); rst_n = 1'b1;
    clear_mon();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (outq.size() != 0) begin
      errors++;
      $display("FAIL idle_no_output: got %0d outputs, required 0", outq.size());
    end
  endtask

  task automatic test_ramp();
    iq_t ys, zs;
    int  last, n;
    logic [16:0] e;
    clear_mon();
    ys = ramp(16, 0);
    zs = model(ys);
    drive_stream(ys, 0, last);
    wait_out(16, 40);
    checks++;
    if (outq.size() != 16) begin
      errors++;
      $display("FAIL ramp_count: got %0d, required 16", outq.size());
    end
    n = (outq.size() < 16) ? outq.size() : 16;
    for (int i = 0; i < n; i++) begin
      e = zs[i][16:0];
      checks++;
      if (outq[i] !== e) begin
        errors++;
        $display("FAIL ramp_z%0d: got %0d, required %0d", i, $signed(outq[i]), zs[i]);
      end
    end
    if (n == 16) begin
      checks++;
      if (outc[0] != last + 1 || outc[15] - outc[0] != 15) begin
        errors++;
        $display("FAIL ramp_timing: first=%0d last=%0d, required first=%0d span=15",
                 outc[0], outc[15], last + 1);
      end
    end
  endtask

  task automatic test_min_value();
    iq_t ys, zs;
    int  last, n;
    logic [16:0] e;
    clear_mon();
    for (int i = 0; i < 16; i++) ys.push_back(-32768);
    zs = model(ys);
    drive_stream(ys, 0, last);
    wait_out(16, 40);
    checks++;
    if (outq.size() != 16) begin
      errors++;
      $display("FAIL min_count: got %0d, required 16", outq.size());
    end
    n = (outq.size() < 16) ? outq.size() : 16;
    for (int i = 0; i < n; i++) begin
      e = zs[i][16:0];
      checks++;
      if (outq[i] !== e) begin
        errors++;
        $display("FAIL min_z%0d: got %0d, required %0d", i, $signed(outq[i]), zs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    iq_t ys, zs;
    int  last, n;
    logic [16:0] e;
    clear_mon();
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 16; i++) ys.push_back(16 * b + i);
    zs = model(ys);
    drive_stream(ys, 0, last);
    wait_out(48, 80);
    checks++;
    if (outq.size() != 48) begin
      errors++;
      $display("FAIL b2b_count: got %0d, required 48", outq.size());
    end
    n = (outq.size() < 48) ? outq.size() : 48;
    for (int i = 0; i < n; i++) begin
      e = zs[i][16:0];
      checks++;
      if (outq[i] !== e) begin
        errors++;
        $display("FAIL b2b_z%0d: got %0d, required %0d", i, $signed(outq[i]), zs[i]);
      end
    end
    if (n == 48) begin
      checks++;
      if (outc[47] - outc[0] != 47 || outc[47] != last + 1 + 15) begin
        errors++;
        $display("FAIL b2b_contiguous: span=%0d end=%0d, required span=47 end=%0d",
                 outc[47] - outc[0], outc[47], last + 16);
      end
    end
  endtask

  task automatic test_gaps();
    iq_t ys, zs;
    int  last, n;
    logic [16:0] e;
    clear_mon();
    ys = ramp(16, 0);
    ys = {ys, rand_block(48)};
    zs = model(ys);
    drive_stream(ys, 50, last);
    wait_out(64, 400);
    checks++;
    if (outq.size() != 64) begin
      errors++;
      $display("FAIL gaps_count: got %0d, required 64", outq.size());
    end
    n = (outq.size() < 64) ? outq.size() : 64;
    for (int i = 0; i < n; i++) begin
      e = zs[i][16:0];
      checks++;
      if (outq[i] !== e) begin
        errors++;
        $display("FAIL gaps_z%0d: got %0d, required %0d", i, $signed(outq[i]), zs[i]);
      end
    end
    for (int b = 0; b + 16 <= n; b += 16) begin
      checks++;
      if (outc[b+15] - outc[b] != 15) begin
        errors++;
        $display("FAIL gaps_block%0d_contiguous: span=%0d, required 15", b / 16, outc[b+15] - outc[b]);
      end
    end
  endtask

  task automatic test_reset_mid();
    iq_t ys, zs;
    int  last, n, b;
    logic [16:0] e;
    clear_mon();
    ys = ramp(9, 100);
    drive_stream(ys, 0, last);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sample !== 17'd0) begin
      errors++;
      $display("FAIL rst_fill: out_valid=%b out_sample=%0d, required 0/0", out_valid, out_sample);
    end
    @(negedge clk); rst_n = 1'b1;
    clear_mon();

    ys = rand_block(16);
    zs = model(ys);
    drive_stream(ys, 0, last);
    b = 0;
    while (outq.size() < 5 && b < 40) begin
      @(posedge clk); #1;
      b++;
    end
    checks++;
    if (outq.size() < 5) begin
      errors++;
      $display("FAIL rst_pre_drain_count: got %0d, required >=5", outq.size());
    end
    n = (outq.size() < 5) ? outq.size() : 5;
    for (int i = 0; i < n; i++) begin
      e = zs[i][16:0];
      checks++;
      if (outq[i] !== e) begin
        errors++;
        $display("FAIL rst_pre_drain_z%0d: got %0d, required %0d", i, $signed(outq[i]), zs[i]);
      end
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sample !== 17'd0) begin
      errors++;
      $display("FAIL rst_drain: out_valid=%b out_sample=%0d, required 0/0", out_valid, out_sample);
    end
    @(negedge clk); rst_n = 1'b1;
    clear_mon();

    ys = ramp(16, 0);
    zs = model(ys);
    drive_stream(ys, 0, last);
    wait_out(16, 40);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (outq.size() != 16) begin
      errors++;
      $display("FAIL rst_clean_count: got %0d, required 16", outq.size());
    end
    n = (outq.size() < 16) ? outq.size() : 16;
    for (int i = 0; i < n; i++) begin
      e = zs[i][16:0];
      checks++;
      if (outq[i] !== e) begin
        errors++;
        $display("FAIL rst_clean_z%0d: got %0d, required %0d", i, $signed(outq[i]), zs[i]);
      end
    end
  endtask

`ifdef DCT16_STAGE2_FRAME_FLAGS_EN
  task automatic test_frame_flags();
    iq_t ys;
    int  last, n;
    clear_mon();
    ys = rand_block(32);
    drive_stream(ys, 0, last);
    wait_out(32, 80);
    checks++;
    if (outq.size() != 32) begin
      errors++;
      $display("FAIL flags_count: got %0d, required 32", outq.size());
    end
    n = (outq.size() < 32) ? outq.size() : 32;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (firstq[i] !== ((i % 16) == 0) || lastq[i] !== ((i % 16) == 15)) begin
        errors++;
        $display("FAIL flags_%0d: first=%b last=%b, required first=%b last=%b",
                 i, firstq[i], lastq[i], (i % 16) == 0, (i % 16) == 15);
      end
    end
    #1;
    checks++;
    if (out_first !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL flags_idle: first=%b last=%b, required 0/0", out_first, out_last);
    end
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    test_ramp();
    test_min_value();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
`ifdef DCT16_STAGE2_FRAME_FLAGS_EN
    test_frame_flags();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
